// File: rtl/demultiplexer_32_buf.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes on every side.
// Each output port owns a one-entry holding register, so a stalled consumer
// only blocks words bound for itself; the other port keeps flowing.
module demultiplexer_32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  input  logic             selector,
  input  logic             inp_valid,
  output logic             inp_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] y2,
  output logic             y2_valid,
  input  logic             y2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  // A port is either EMPTY (nothing to offer) or FULL (holding one word).
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state1;
  logic [0:0]       r_state2;
  logic [WIDTH-1:0] r_y1;
  logic [WIDTH-1:0] r_y2;
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] r_cnt2;

  logic [0:0] w_state1Next;
  logic [0:0] w_state2Next;
  logic       w_full1;
  logic       w_full2;
  logic       w_slotFree1;
  logic       w_slotFree2;
  logic       w_drain1;
  logic       w_drain2;
  logic       w_inpReady;
  logic       w_accept;
  logic       w_accept1;
  logic       w_accept2;

  assign w_full1 = (r_state1 == ST_FULL);
  assign w_full2 = (r_state2 == ST_FULL);

  // A slot can take a new word if it is empty or its word leaves this cycle.
  assign w_slotFree1 = ~w_full1 | y1_ready;
  assign w_slotFree2 = ~w_full2 | y2_ready;

  assign w_drain1 = w_full1 & y1_ready;
  assign w_drain2 = w_full2 & y2_ready;

  // Readiness looks only at the port the current word is aimed at, so the
  // producer can retarget a blocked word to the other port without losing it.
  assign w_inpReady = selector ? w_slotFree2 : w_slotFree1;

  assign w_accept  = inp_valid & w_inpReady;
  assign w_accept1 = w_accept & ~selector;
  assign w_accept2 = w_accept &  selector;

  // Port 1 next state: an accept wins over a drain so back-to-back words keep it FULL.
  always_comb begin
    w_state1Next = r_state1;
    if (w_accept1) begin
      w_state1Next = ST_FULL;
    end else if (w_drain1) begin
      w_state1Next = ST_EMPTY;
    end
  end

  // Port 2 next state: same rule as port 1, fully independent of it.
  always_comb begin
    w_state2Next = r_state2;
    if (w_accept2) begin
      w_state2Next = ST_FULL;
    end else if (w_drain2) begin
      w_state2Next = ST_EMPTY;
    end
  end

  // Port 1 state register; reset drops any held word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state1 <= ST_EMPTY;
    end else begin
      r_state1 <= w_state1Next;
    end
  end

  // Port 2 state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state2 <= ST_EMPTY;
    end else begin
      r_state2 <= w_state2Next;
    end
  end

  // Port 1 data holds its last word after a drain; it is only loaded on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y1 <= '0;
    end else if (w_accept1) begin
      r_y1 <= inp;
    end
  end

  // Port 2 data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y2 <= '0;
    end else if (w_accept2) begin
      r_y2 <= inp;
    end
  end

  // Port 1 accept counter; wraps naturally at 2^CNT_W and ignores drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt1 <= '0;
    end else if (w_accept1) begin
      r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  // Port 2 accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt2 <= '0;
    end else if (w_accept2) begin
      r_cnt2 <= r_cnt2 + CNT_W'(1);
    end
  end

  assign inp_ready = w_inpReady;
  assign y1        = r_y1;
  assign y1_valid  = w_full1;
  assign y2        = r_y2;
  assign y2_valid  = w_full2;
  assign cnt1      = r_cnt1;
  assign cnt2      = r_cnt2;

endmodule

// File: tb/tb_demultiplexer_32_buf.sv
// Directed testbench for demultiplexer_32_buf. The DUT is built with a
// 4-bit counter width so counter wrap-around is reachable in a few cycles.
module tb_demultiplexer_32_buf;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] inp;
  logic             selector;
  logic             inp_valid;
  logic             inp_ready;
  logic [WIDTH-1:0] y1;
  logic             y1_valid;
  logic             y1_ready;
  logic [WIDTH-1:0] y2;
  logic             y2_valid;
  logic             y2_ready;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;

  int testsRun;
  int testsFailed;

  demultiplexer_32_buf #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inp      (inp),
    .selector (selector),
    .inp_valid(inp_valid),
    .inp_ready(inp_ready),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .y2       (y2),
    .y2_valid (y2_valid),
    .y2_ready (y2_ready),
    .cnt1     (cnt1),
    .cnt2     (cnt2)
  );

  // 10 ns clock; inputs change and outputs are sampled 1 ns after the rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inp       = '0;
    selector  = 1'b0;
    inp_valid = 1'b0;
    y1_ready  = 1'b0;
    y2_ready  = 1'b0;
  endtask

  // Synchronous-looking reset pulse used between scenarios.
  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    // Power-on state.
    testsRun++;
    if (y1_valid !== 1'b0 || y2_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_valid: y1_valid=%b y2_valid=%b expected 0 0", y1_valid, y2_valid);
    end
    testsRun++;
    if (y1 !== 32'h0 || y2 !== 32'h0 || cnt1 !== 4'd0 || cnt2 !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: y1=%h y2=%h cnt1=%0d cnt2=%0d expected all 0", y1, y2, cnt1, cnt2);
    end
    // Fill port 1 with five words, last one stays held.
    for (int i = 0; i < 5; i++) begin
      inp       = 32'h100 + i;
      selector  = 1'b0;
      inp_valid = 1'b1;
      y1_ready  = 1'b1;
      step();
    end
    inp_valid = 1'b0;
    y1_ready  = 1'b0;
    testsRun++;
    if (y1_valid !== 1'b1 || cnt1 !== 4'd5 || y1 !== 32'h104) begin
      testsFailed++;
      $display("[TB] FAIL reset_prefill: y1_valid=%b cnt1=%0d y1=%h expected 1 5 00000104", y1_valid, cnt1, y1);
    end
    // Assert reset mid-cycle; outputs must clear before the next edge.
    #2;
    rst = 1'b1;
    #1;
    testsRun++;
    if (y1_valid !== 1'b0 || cnt1 !== 4'd0 || y1 !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: y1_valid=%b cnt1=%0d y1=%h expected 0 0 00000000", y1_valid, cnt1, y1);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_route();
    inp       = 32'hDEADBEEF;
    selector  = 1'b1;
    inp_valid = 1'b1;
    y2_ready  = 1'b1;
    #1;
    testsRun++;
    if (inp_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_ready: inp_ready=%b expected 1", inp_ready);
    end
    step();
    inp_valid = 1'b0;
    testsRun++;
    if (y2 !== 32'hDEADBEEF || y2_valid !== 1'b1 || y1_valid !== 1'b0 || cnt2 !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL basic_route: y2=%h y2_valid=%b y1_valid=%b cnt2=%0d expected deadbeef 1 0 1",
               y2, y2_valid, y1_valid, cnt2);
    end
    step();
    testsRun++;
    if (y2_valid !== 1'b0 || cnt2 !== 4'd1 || y2 !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL basic_drain: y2_valid=%b cnt2=%0d y2=%h expected 0 1 deadbeef", y2_valid, cnt2, y2);
    end
  endtask

  task automatic test_independent_stall();
    doReset();
    y1_ready  = 1'b0;
    y2_ready  = 1'b1;
    inp       = 32'hAAAA0001;
    selector  = 1'b0;
    inp_valid = 1'b1;
    step();
    // Offer B to the stalled port 1.
    inp = 32'hBBBB0002;
    #1;
    testsRun++;
    if (inp_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stall_blockB: inp_ready=%b expected 0", inp_ready);
    end
    step();
    testsRun++;
    if (y1 !== 32'hAAAA0001 || y1_valid !== 1'b1 || cnt1 !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL stall_holdA: y1=%h y1_valid=%b cnt1=%0d expected aaaa0001 1 1", y1, y1_valid, cnt1);
    end
    // Retarget to port 2 with C.
    inp      = 32'hCCCC0003;
    selector = 1'b1;
    #1;
    testsRun++;
    if (inp_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stall_readyC: inp_ready=%b expected 1", inp_ready);
    end
    step();
    inp_valid = 1'b0;
    testsRun++;
    if (y2 !== 32'hCCCC0003 || y2_valid !== 1'b1 || y1 !== 32'hAAAA0001 || y1_valid !== 1'b1 || cnt2 !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL stall_routeC: y2=%h y2_valid=%b y1=%h y1_valid=%b cnt2=%0d expected cccc0003 1 aaaa0001 1 1",
               y2, y2_valid, y1, y1_valid, cnt2);
    end
    y1_ready = 1'b1;
    step();
    testsRun++;
    if (y1_valid !== 1'b0 || y2_valid !== 1'b0 || cnt1 !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL stall_release: y1_valid=%b y2_valid=%b cnt1=%0d expected 0 0 1", y1_valid, y2_valid, cnt1);
    end
  endtask

  task automatic test_streaming();
    doReset();
    y1_ready = 1'b1;
    selector = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inp       = i;
      inp_valid = 1'b1;
      #1;
      testsRun++;
      if (inp_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL stream_ready[%0d]: inp_ready=%b expected 1", i, inp_ready);
      end
      step();
      testsRun++;
      if (y1 !== 32'(i) || y1_valid !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL stream_data[%0d]: y1=%h y1_valid=%b expected %h 1", i, y1, y1_valid, 32'(i));
      end
    end
    inp_valid = 1'b0;
    step();
    testsRun++;
    if (cnt1 !== 4'd8 || y1_valid !== 1'b0 || cnt2 !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL stream_count: cnt1=%0d y1_valid=%b cnt2=%0d expected 8 0 0", cnt1, y1_valid, cnt2);
    end
  endtask

  task automatic test_counter_wrap();
    doReset();
    y2_ready  = 1'b1;
    selector  = 1'b1;
    inp_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      inp = 32'h2000 + i;
      step();
      if (i == 15) begin
        testsRun++;
        if (cnt2 !== 4'd0) begin
          testsFailed++;
          $display("[TB] FAIL wrap_zero: cnt2=%0d expected 0", cnt2);
        end
      end
    end
    inp_valid = 1'b0;
    testsRun++;
    if (cnt2 !== 4'd1 || cnt1 !== 4'd0 || y2 !== 32'h2010) begin
      testsFailed++;
      $display("[TB] FAIL wrap_final: cnt2=%0d cnt1=%0d y2=%h expected 1 0 00002010", cnt2, cnt1, y2);
    end
    step();
  endtask

  task automatic test_backpressure();
    doReset();
    y2_ready  = 1'b0;
    inp       = 32'h1234;
    selector  = 1'b1;
    inp_valid = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      inp = $urandom;
      #1;
      testsRun++;
      if (inp_ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp_ready[%0d]: inp_ready=%b expected 0", i, inp_ready);
      end
      step();
      testsRun++;
      if (y2 !== 32'h1234 || y2_valid !== 1'b1 || cnt2 !== 4'd1) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold[%0d]: y2=%h y2_valid=%b cnt2=%0d expected 00001234 1 1", i, y2, y2_valid, cnt2);
      end
    end
    inp_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Port 2 holds 1234; drain and accept on the same edge keeps it full.
    y2_ready  = 1'b1;
    inp       = 32'h5678;
    selector  = 1'b1;
    inp_valid = 1'b1;
    step();
    testsRun++;
    if (y2 !== 32'h5678 || y2_valid !== 1'b1 || cnt2 !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL b2b_replace: y2=%h y2_valid=%b cnt2=%0d expected 00005678 1 2", y2, y2_valid, cnt2);
    end
    // Load port 1 and stall it; port 2 readiness must ignore port 1.
    y2_ready = 1'b0;
    y1_ready = 1'b0;
    inp      = 32'h9ABC;
    selector = 1'b0;
    step();
    y2_ready = 1'b1;
    inp      = 32'hDEF0;
    selector = 1'b1;
    #1;
    testsRun++;
    if (inp_ready !== 1'b1 || y1_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_ignoreOther: inp_ready=%b y1_valid=%b expected 1 1", inp_ready, y1_valid);
    end
    // Port 1 drains while port 2 accepts on the same edge.
    y1_ready = 1'b1;
    step();
    inp_valid = 1'b0;
    y2_ready  = 1'b0;
    testsRun++;
    if (y1_valid !== 1'b0 || y1 !== 32'h9ABC || y2 !== 32'hDEF0 || y2_valid !== 1'b1 || cnt1 !== 4'd1 || cnt2 !== 4'd3) begin
      testsFailed++;
      $display("[TB] FAIL b2b_cross: y1_valid=%b y1=%h y2=%h y2_valid=%b cnt1=%0d cnt2=%0d expected 0 00009abc 0000def0 1 1 3",
               y1_valid, y1, y2, y2_valid, cnt1, cnt2);
    end
    // Idle input: nothing but drains happen.
    step();
    testsRun++;
    if (y2_valid !== 1'b1 || y2 !== 32'hDEF0 || cnt2 !== 4'd3) begin
      testsFailed++;
      $display("[TB] FAIL b2b_idle: y2_valid=%b y2=%h cnt2=%0d expected 1 0000def0 3", y2_valid, y2, cnt2);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    idleInputs();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic_route();
    test_independent_stall();
    test_streaming();
    test_counter_wrap();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
